// File: rtl/muxn_rr_reg.sv
// N-way WIDTH-bit multiplexer with fixed-select or round-robin grant, a one-entry
// registered output stage and valid/ready handshakes on every channel.
module muxn_rr_reg #(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   d,
  input  logic [N-1:0]         d_valid,
  output logic [N-1:0]         d_ready,
  output logic [WIDTH-1:0]     y,
  output logic [SELW-1:0]      y_ch,
  output logic                 y_valid,
  input  logic                 y_ready
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  y_ch_q, y_ch_d;
  logic             y_valid_q, y_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en_s;
  logic             gnt_found_s;
  logic [SELW-1:0]  gnt_s;
  logic             xfer_s;
  logic [SELW-1:0]  ptr_next_s;

  // Grant selection: fixed channel from sel, or first valid channel at/after ptr.
  always_comb begin
    int  idx;
    logic hit;
    gnt_found_s = 1'b0;
    gnt_s       = '0;
    idx         = 0;
    hit         = 1'b0;
    if (mode) begin
      for (int k = 0; k < N; k++) begin
        idx         = (int'(ptr_q) + k) % N;
        hit         = !gnt_found_s && d_valid[idx];
        gnt_s       = hit ? SELW'(idx) : gnt_s;
        gnt_found_s = gnt_found_s | hit;
      end
    end else begin
      // A sel value >= N simply matches no channel, so it never grants.
      for (int i = 0; i < N; i++) begin
        hit         = (sel == SELW'(i)) && d_valid[i];
        gnt_s       = hit ? SELW'(i) : gnt_s;
        gnt_found_s = gnt_found_s | hit;
      end
    end
  end

  assign load_en_s  = !y_valid_q | y_ready;
  assign xfer_s     = reset_n & load_en_s & gnt_found_s;
  assign ptr_next_s = (int'(gnt_s) == N - 1) ? '0 : gnt_s + SELW'(1);

  // Per-channel ready: only the granted channel, only when the output can load.
  always_comb begin
    d_ready = '0;
    for (int i = 0; i < N; i++) begin
      d_ready[i] = xfer_s & (gnt_s == SELW'(i));
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = y_valid_q;
    ptr_d     = ptr_q;
    if (xfer_s) begin
      y_d       = d[int'(gnt_s)*WIDTH +: WIDTH];
      y_ch_d    = gnt_s;
      y_valid_d = 1'b1;
      ptr_d     = mode ? ptr_next_s : ptr_q;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end else begin
      y_valid_d = y_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Scoreboard bench for muxn_rr_reg (WIDTH=4, N=4): a reference model predicts
// grants and d_ready, queues expected words, and checks them as they drain.
module tb_muxn_rr_reg;

  localparam int WIDTH = 4;
  localparam int N     = 4;

  logic         clk;
  logic         reset_n;
  logic         mode;
  logic [1:0]   sel;
  logic [15:0]  d;
  logic [3:0]   d_valid;
  logic [3:0]   d_ready;
  logic [3:0]   y;
  logic [1:0]   y_ch;
  logic         y_valid;
  logic         y_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic m_yv  = 1'b0;
  int   m_ptr = 0;
  int   sb[$];

  muxn_rr_reg #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
    .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .y(y), .y_ch(y_ch), .y_valid(y_valid), .y_ready(y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int model_gnt(input logic m, input int s, input logic [3:0] v, input int p);
    if (!m) return (s < N && v[s]) ? s : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock: check mid-cycle against the model, advance model, step past the edge.
  task automatic cycle();
    int         g;
    int         e;
    logic       ld;
    logic [3:0] er;
    #3;
    ld = !m_yv || y_ready;
    g  = model_gnt(mode, int'(sel), d_valid, m_ptr);
    er = 4'b0000;
    if (reset_n && ld && g >= 0) er[g] = 1'b1;
    chk("d_ready", d_ready, er);
    chk("y_valid", y_valid, m_yv);
    if (reset_n && m_yv && y_ready && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_y", y, e & 15);
      chk("sb_y_ch", y_ch, e >> 4);
    end
    if (!reset_n) begin
      m_yv  = 1'b0;
      m_ptr = 0;
      sb.delete();
    end else if (ld && g >= 0) begin
      sb.push_back((g << 4) | int'(d[g*WIDTH +: WIDTH]));
      m_yv = 1'b1;
      if (mode) m_ptr = (g + 1) % N;
    end else if (m_yv && y_ready) begin
      m_yv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; mode = 1'b1; sel = 2'd0;
    d = 16'h3210; d_valid = 4'b1111; y_ready = 1'b1;
    @(posedge clk);
    #1;

    // 1. Reset held with all channels valid
    cycle();
    cycle();
    chk("rst_y", y, 4'h0);
    chk("rst_y_ch", y_ch, 2'd0);
    reset_n = 1'b1;
    cycle();
    chk("first_rr_ch", y_ch, 2'd0);

    // 2. Fixed select
    mode = 1'b0; d = 16'h00F0; d_valid = 4'b0011;
    sel = 2'd0; cycle();
    chk("sel0_y", y, 4'h0);
    chk("sel0_ch", y_ch, 2'd0);
    sel = 2'd1; cycle();
    chk("sel1_y", y, 4'hF);
    chk("sel1_ch", y_ch, 2'd1);
    sel = 2'd2; cycle();
    chk("sel2_novalid", y_valid, 1'b0);

    // 3. Round-robin fairness from a fresh pointer
    reset_n = 1'b0; cycle();
    reset_n = 1'b1; mode = 1'b1; d = 16'h3210; d_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_ch", y_ch, i % 4);
      chk("rr_y", y, i % 4);
      chk("rr_valid", y_valid, 1'b1);
    end

    // 4. Back-pressure
    d = 16'h765A; d_valid = 4'b0011;
    cycle();
    chk("bp_first", y, 4'hA);
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_y", y, 4'hA);
      chk("bp_hold_ch", y_ch, 2'd0);
    end
    y_ready = 1'b1;
    cycle();
    chk("bp_next_ch", y_ch, 2'd1);
    chk("bp_next_y", y, 4'h5);
    d_valid = 4'b0000; cycle();

    // 5. Sparse requesters and wrap
    d = 16'h4321;
    d_valid = 4'b0100; cycle();
    chk("sp_ch2", y_ch, 2'd2);
    d_valid = 4'b0010; cycle();
    chk("sp_ch1", y_ch, 2'd1);
    d_valid = 4'b0101; cycle();
    chk("sp_ch2b", y_ch, 2'd2);
    cycle();
    chk("sp_ch0", y_ch, 2'd0);
    chk("sp_ch0_y", y, 4'h1);
    d_valid = 4'b0000; cycle();

    // 6. Reset while holding a stalled word
    d = 16'hDCBE; d_valid = 4'b0001; cycle();
    chk("mid_load", y, 4'hE);
    y_ready = 1'b0; d_valid = 4'b1111; reset_n = 1'b0; cycle();
    chk("mid_rst_valid", y_valid, 1'b0);
    chk("mid_rst_y", y, 4'h0);
    reset_n = 1'b1; y_ready = 1'b1; cycle();
    chk("mid_rst_ptr", y_ch, 2'd0);
    d_valid = 4'b0000; cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muxn_rr_reg.md
Name: muxn_rr_reg

Overview:
- Parametrised N-way, WIDTH-bit multiplexer with a one-entry registered output and valid/ready handshakes on every input channel and on the output.
- Generalises the combinational 2:1 data selector in two ways: a channel count set by parameter, and two select modes. The modes are fixed select, driven by the `sel` port, and round-robin arbitration among valid channels.
- Sits between multiple producers and one consumer in the datapath examples.
- Also reports which channel each output word came from.

Parameters:
- WIDTH, 4, data bits per channel.
- N, 4, number of input channels (2..16).
- SELW, $clog2(N), width of the channel index. Derived; must not be overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- mode  in  1  0 = fixed select via sel; 1 = round-robin.
- sel  in  SELW  channel index used when mode=0.
- d  in  N*WIDTH  flattened inputs; channel i occupies d[i*WIDTH +: WIDTH].
- d_valid  in  N  per-channel valid.
- d_ready  out  N  per-channel ready. Combinational; at most one bit high.
- y  out  WIDTH  registered output data.
- y_ch  out  SELW  index of the channel that supplied y.
- y_valid  out  1  output register holds a word.
- y_ready  in  1  consumer accepts y.

Behaviour:
- Reset: when reset_n=0 at a clk edge, the block sets y=0, y_ch=0, y_valid=0 and the round-robin pointer ptr=0.
  - d_ready is all-zero while reset_n=0.
  - Reset mid-operation discards the held word without any handshake.
- Load enable: load_en = !y_valid | y_ready. The output register can be refilled in the same cycle it drains, so full throughput is one word per cycle.
- Grant, mode=0:
  - gnt = sel when d_valid[sel]=1 and sel<N.
  - Otherwise there is no grant. Valid data on other channels is ignored.
- Grant, mode=1: gnt = the first i with d_valid[i]=1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (mod N). If no channel is valid there is no grant.
- Ready: d_ready[i] = load_en & grant_exists & (gnt==i). d_ready is independent of d_valid[i] except through the grant.
- Transfer on channel i occurs when d_valid[i] & d_ready[i]. At that clk edge:
  - y <= d[i]; y_ch <= i; y_valid <= 1.
  - In mode=1, ptr <= (i+1) mod N, wrapping from N-1 to 0.
- Drain without refill: if y_valid & y_ready and no transfer occurs, then y_valid <= 0. y and y_ch hold their last values.
- Stall: while y_valid=1 and y_ready=0, y and y_ch hold stable and d_ready=0 on all channels.
- Latency: one cycle, from input handshake to y_valid.
- ptr:
  - Changes only on a transfer in mode=1.
  - Is retained across mode changes and across mode=0 operation.
- A mode or sel change takes effect in the same cycle's grant (combinational), so it has no effect on a word already held.
- Inputs are assumed to follow the valid/ready rule: a producer holds d and d_valid until its handshake completes. The block does not check this.

Test Plan (WIDTH=4, N=4):
1. Reset: hold reset_n=0 for 2 cycles with all d_valid=1.
   -> y=0, y_ch=0, y_valid=0, d_ready=0000 throughout. After release, the first grant in mode=1 goes to channel 0.
2. Fixed select, two-way case: mode=0, d0=4'h0, d1=4'hF, d_valid=0011, y_ready=1.
   - sel=0 -> next cycle y=4'h0, y_ch=0.
   - sel=1 -> y=4'hF, y_ch=1.
   - sel=2 with d_valid[2]=0 -> no transfer, y_valid=0 the following cycle.
3. Round-robin fairness: mode=1, all four channels valid, d=3,2,1,0 (ch3..ch0), y_ready=1 for 8 cycles.
   -> y_ch sequence 0,1,2,3,0,1,2,3; y sequence 0,1,2,3,0,1,2,3; one word per cycle.
4. Back-pressure: mode=1, y_ready=0 for 3 cycles after the first word (ch0=4'hA).
   -> y=4'hA, y_valid=1 stable; d_ready=0000. On y_ready=1, the next word loads in the same cycle, from ch1.
5. Sparse requesters and wrap: mode=1, ptr=3 (reached by a prior grant to ch2), d_valid=0010.
   -> ch1 is granted, ptr becomes 2. Then d_valid=0101 -> ch2 is granted, then ch0.
6. Reset mid-operation: y_valid=1, y_ready=0, pulse reset_n=0 for 1 cycle.
   -> y_valid=0, y=0, ptr=0 on the next cycle; the held word is lost and no d_ready was asserted during reset.
